// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcode constants, immediate formats and
// small opcode classification helpers used by decode and execute.
package rv32_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_OPCODE_WIDTH   = 7;
    localparam int DEFAULT_REG_ADDR_WIDTH = 5;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    // Unsupported opcodes (and plain OP) carry no immediate.
    function automatic imm_type_e imm_type_of(input logic [6:0] opc);
        imm_type_e t;
        case (opc)
            OP_IMM, LOAD, JALR: t = IMM_I;
            STORE:              t = IMM_S;
            BRANCH:             t = IMM_B;
            LUI, AUIPC:         t = IMM_U;
            JAL:                t = IMM_J;
            default:            t = IMM_NONE;
        endcase
        return t;
    endfunction

    function automatic logic opcode_legal(input logic [6:0] opc);
        logic ok;
        case (opc)
            LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP: ok = 1'b1;
            default:                                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic opcode_has_rs2(input logic [6:0] opc);
        return (opc == BRANCH) || (opc == STORE) || (opc == OP);
    endfunction

endpackage

// File: rtl/reg_file.sv
// Integer register file: two asynchronous read ports, one synchronous
// write port, x0 hardwired to zero, cleared by reset.
module reg_file
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr1,
    output logic [DATA_WIDTH-1:0]     rd_data1,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0]     rd_data2
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Write port; index 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read ports with explicit x0 forcing.
    always_comb begin
        rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
        rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with the ID/EX pipeline register. Accepts beats from
// IF, reads operands (with writeback bypass), builds the immediate and
// holds a registered bundle for EX under a valid/ready handshake.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int OPCODE_WIDTH   = DEFAULT_OPCODE_WIDTH,
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      if_valid,
    output logic                      if_ready,
    input  logic [DATA_WIDTH-1:0]     if_pc,
    input  logic [31:0]               if_instr,
    input  logic                      flush,
    output logic                      ex_valid,
    input  logic                      ex_ready,
    output logic [DATA_WIDTH-1:0]     pc_out,
    output logic [DATA_WIDTH-1:0]     rs1_out,
    output logic [DATA_WIDTH-1:0]     rs2_out,
    output logic [DATA_WIDTH-1:0]     imm_out,
    output logic [OPCODE_WIDTH-1:0]   opcode,
    output logic [2:0]                funct3,
    output logic [6:0]                funct7,
    output logic [REG_ADDR_WIDTH-1:0] rd_out,
    output logic                      illegal,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_data
);

    logic [6:0]                opc;
    logic [2:0]                f3;
    logic [REG_ADDR_WIDTH-1:0] rs1_idx;
    logic [REG_ADDR_WIDTH-1:0] rs2_idx;
    logic [REG_ADDR_WIDTH-1:0] rd_idx;
    imm_type_e                 imm_type;
    logic [31:0]               imm32;
    logic [6:0]                f7_clean;
    logic [DATA_WIDTH-1:0]     rf_rd1;
    logic [DATA_WIDTH-1:0]     rf_rd2;
    logic [DATA_WIDTH-1:0]     rs1_val;
    logic [DATA_WIDTH-1:0]     rs2_val;
    logic                      wb_write;
    logic                      accept;

    // Indices of the operands captured with the held bundle, for refresh.
    logic [REG_ADDR_WIDTH-1:0] held_rs1_idx;
    logic [REG_ADDR_WIDTH-1:0] held_rs2_idx;

    assign opc      = if_instr[6:0];
    assign f3       = if_instr[14:12];
    assign rs1_idx  = REG_ADDR_WIDTH'(if_instr[19:15]);
    // Opcodes without rs2 read x0, which makes RS2_OUT zero for free and
    // keeps a held bundle from ever being refreshed on rs2.
    assign rs2_idx  = opcode_has_rs2(opc) ? REG_ADDR_WIDTH'(if_instr[24:20]) : '0;
    assign rd_idx   = REG_ADDR_WIDTH'(if_instr[11:7]);
    assign imm_type = imm_type_of(opc);

    assign wb_write = wb_en && (wb_rd != '0);
    assign if_ready = !ex_valid || ex_ready;
    assign accept   = if_valid && if_ready && !flush;

    reg_file #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wb_en),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data),
        .rd_addr1 (rs1_idx),
        .rd_data1 (rf_rd1),
        .rd_addr2 (rs2_idx),
        .rd_data2 (rf_rd2)
    );

    // Immediate assembly for each instruction format.
    always_comb begin
        imm32 = '0;
        case (imm_type)
            IMM_I: imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            IMM_S: imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            IMM_B: imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                            if_instr[30:25], if_instr[11:8], 1'b0};
            IMM_U: imm32 = {if_instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                            if_instr[20], if_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // funct7 only passes through where it really selects an ALU variant, so
    // an I-type immediate with bit30 set cannot look like SUB/SRA downstream.
    always_comb begin
        f7_clean = 7'd0;
        if ((opc == OP) || ((opc == OP_IMM) && ((f3 == 3'b001) || (f3 == 3'b101)))) begin
            f7_clean = if_instr[31:25];
        end
    end

    // Operand capture with same-cycle writeback bypass.
    always_comb begin
        rs1_val = rf_rd1;
        rs2_val = rf_rd2;
        if (wb_write && (wb_rd == rs1_idx)) rs1_val = wb_data;
        if (wb_write && (wb_rd == rs2_idx)) rs2_val = wb_data;
    end

    // ID/EX register: flush wins, then accept, then drain, else hold with refresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            pc_out       <= '0;
            rs1_out      <= '0;
            rs2_out      <= '0;
            imm_out      <= '0;
            opcode       <= '0;
            funct3       <= '0;
            funct7       <= '0;
            rd_out       <= '0;
            illegal      <= 1'b0;
            held_rs1_idx <= '0;
            held_rs2_idx <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid     <= 1'b1;
            pc_out       <= if_pc;
            rs1_out      <= rs1_val;
            rs2_out      <= rs2_val;
            imm_out      <= DATA_WIDTH'($signed(imm32));
            opcode       <= OPCODE_WIDTH'(opc);
            funct3       <= f3;
            funct7       <= f7_clean;
            rd_out       <= rd_idx;
            illegal      <= !opcode_legal(opc);
            held_rs1_idx <= rs1_idx;
            held_rs2_idx <= rs2_idx;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end else if (ex_valid && wb_write) begin
            if (wb_rd == held_rs1_idx) rs1_out <= wb_data;
            if (wb_rd == held_rs2_idx) rs2_out <= wb_data;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a reference model predicts the ID/EX bundle each
// cycle into a queue; a monitor pops and compares on every falling edge.
// Directed beats add fixed-value checks on top of the randomized traffic.
module tb_decode_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        ill;
        logic [4:0]  s1;
        logic [4:0]  s2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] pc_out;
    logic [31:0] rs1_out;
    logic [31:0] rs2_out;
    logic [31:0] imm_out;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_out;
    logic        illegal;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    logic [31:0] m_regs [32];
    logic        m_valid;
    exp_t        m_b;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .flush    (flush),
        .ex_valid (ex_valid),
        .ex_ready (ex_ready),
        .pc_out   (pc_out),
        .rs1_out  (rs1_out),
        .rs2_out  (rs2_out),
        .imm_out  (imm_out),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .rd_out   (rd_out),
        .illegal  (illegal),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Immediate value computed arithmetically from the format definitions.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int v;
        int hi;
        v = 0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: v = $signed(ins) >>> 20;
            7'h23: begin
                hi = $signed(ins) >>> 25;
                v  = hi * 32 + int'(ins[11:7]);
            end
            7'h63: v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
                       + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            7'h37, 7'h17: v = int'(ins & 32'hFFFF_F000);
            7'h6F: v = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096
                       + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic exp_t ref_beat(input logic [31:0] pc, input logic [31:0] ins);
        exp_t       b;
        logic [6:0] op;
        op      = ins[6:0];
        b       = '0;
        b.valid = 1'b1;
        b.pc    = pc;
        b.opc   = op;
        b.f3    = ins[14:12];
        b.rd    = ins[11:7];
        b.ill   = !(op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33});
        b.imm   = ref_imm(ins);
        b.f7    = (op == 7'h33 || (op == 7'h13 && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5)))
                  ? ins[31:25] : 7'd0;
        b.s1    = ins[19:15];
        b.s2    = (op inside {7'h63, 7'h23, 7'h33}) ? ins[24:20] : 5'd0;
        return b;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_rd == idx) return wb_data;
        return m_regs[idx];
    endfunction

    // Reference model: one expectation pushed per rising edge.
    initial begin
        m_valid = 1'b0;
        m_b     = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_valid = 1'b0;
                for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            end else begin
                logic rdy;
                rdy = !m_valid || ex_ready;
                if (flush) begin
                    m_valid = 1'b0;
                end else if (if_valid && rdy) begin
                    m_b     = ref_beat(if_pc, if_instr);
                    m_b.rs1 = ref_read(m_b.s1);
                    m_b.rs2 = ref_read(m_b.s2);
                    m_valid = 1'b1;
                end else if (ex_ready) begin
                    m_valid = 1'b0;
                end else if (m_valid && wb_en && wb_rd != 5'd0) begin
                    if (wb_rd == m_b.s1) m_b.rs1 = wb_data;
                    if (wb_rd == m_b.s2) m_b.rs2 = wb_data;
                end
                if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
                m_b.valid = m_valid;
                exp_q.push_back(m_b);
            end
        end
    end

    // Monitor: compare the live DUT state against the model each falling edge.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (rst_n) begin
                    check("ex_valid", 64'(ex_valid), 64'(e.valid));
                    check("if_ready", 64'(if_ready), 64'(!e.valid || ex_ready));
                    if (e.valid && ex_valid) begin
                        checks++;
                        if ({pc_out, rs1_out, rs2_out, imm_out, opcode, funct3, funct7, rd_out, illegal}
                            !== {e.pc, e.rs1, e.rs2, e.imm, e.opc, e.f3, e.f7, e.rd, e.ill}) begin
                            errors++;
                            $display("FAIL bundle actual pc=%h rs1=%h rs2=%h imm=%h op=%h f3=%h f7=%h rd=%0d ill=%b required pc=%h rs1=%h rs2=%h imm=%h op=%h f3=%h f7=%h rd=%0d ill=%b at %0t",
                                     pc_out, rs1_out, rs2_out, imm_out, opcode, funct3, funct7, rd_out, illegal,
                                     e.pc, e.rs1, e.rs2, e.imm, e.opc, e.f3, e.f7, e.rd, e.ill, $time);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_imm(input logic [31:0] pc, input logic [31:0] ins,
                            input logic [31:0] exp_imm, input string name);
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = ins;
        step();
        if_valid = 1'b0;
        check(name, 64'(imm_out), 64'(exp_imm));
    endtask

    function automatic logic [6:0] pick_opc(input int k);
        case (k)
            0: return 7'h37;
            1: return 7'h17;
            2: return 7'h6F;
            3: return 7'h67;
            4: return 7'h63;
            5: return 7'h03;
            6: return 7'h23;
            7: return 7'h13;
            8: return 7'h33;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] ins;
        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_pc    = 32'd0;
        if_instr = 32'd0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        wb_en    = 1'b0;
        wb_rd    = 5'd0;
        wb_data  = 32'd0;
        #3;
        check("reset ex_valid", 64'(ex_valid), 64'd0);
        check("reset if_ready", 64'(if_ready), 64'd1);
        check("reset pc_out", 64'(pc_out), 64'd0);
        check("reset imm_out", 64'(imm_out), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // ADDI x1,x0,-1
        beat_imm(32'h100, 32'hFFF0_0093, 32'hFFFF_FFFF, "addi imm");
        check("addi ex_valid", 64'(ex_valid), 64'd1);
        check("addi rs1", 64'(rs1_out), 64'd0);
        check("addi funct7", 64'(funct7), 64'd0);
        check("addi rd", 64'(rd_out), 64'd1);
        check("addi illegal", 64'(illegal), 64'd0);

        // ADD x6,x5,x5 while writeback writes x5
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        beat_imm(32'h104, 32'h0052_8333, 32'd0, "add imm");
        wb_en = 1'b0;
        check("bypass rs1", 64'(rs1_out), 64'hDEAD_BEEF);
        check("bypass rs2", 64'(rs2_out), 64'hDEAD_BEEF);
        check("add funct7", 64'(funct7), 64'd0);

        beat_imm(32'h108, 32'hFE00_0EE3, 32'hFFFF_FFFC, "beq imm");
        beat_imm(32'h10C, 32'h0010_006F, 32'h0000_0800, "jal imm");
        beat_imm(32'h110, 32'h1234_50B7, 32'h1234_5000, "lui imm");
        step();

        // Hold: A = ADDI x8,x3,1 held while B = ADDI x9,x3,2 waits
        ex_ready = 1'b0;
        beat_imm(32'h200, 32'h0011_8413, 32'd1, "hold A imm");
        if_valid = 1'b1; if_pc = 32'h204; if_instr = 32'h0021_8493;
        for (int i = 0; i < 3; i++) begin
            check("hold if_ready", 64'(if_ready), 64'd0);
            if (i == 1) begin
                wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
            end
            step();
            wb_en = 1'b0;
            check("hold pc", 64'(pc_out), 64'h200);
            check("hold imm", 64'(imm_out), 64'd1);
            if (i >= 1) check("hold refresh rs1", 64'(rs1_out), 64'h55);
        end
        ex_ready = 1'b1;
        step();
        if_valid = 1'b0;
        check("release pc", 64'(pc_out), 64'h204);
        check("release imm", 64'(imm_out), 64'd2);
        check("release rs1", 64'(rs1_out), 64'h55);
        step();
        check("no duplicate", 64'(ex_valid), 64'd0);

        // Flush with a held beat and an incoming beat; also write x0
        ex_ready = 1'b0;
        beat_imm(32'h300, 32'hFFF0_0093, 32'hFFFF_FFFF, "flush A imm");
        if_valid = 1'b1; if_pc = 32'h304; if_instr = 32'h0011_8413;
        flush = 1'b1; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        step();
        flush = 1'b0; wb_en = 1'b0; if_valid = 1'b0;
        check("flush ex_valid", 64'(ex_valid), 64'd0);
        step();
        check("flush dropped", 64'(ex_valid), 64'd0);
        ex_ready = 1'b1;
        beat_imm(32'h308, 32'h0000_04B3, 32'd0, "x0 add imm");
        check("x0 rs1", 64'(rs1_out), 64'd0);
        check("x0 rs2", 64'(rs2_out), 64'd0);

        // Unsupported opcode 0x7F
        beat_imm(32'h30C, 32'hFFFF_FFFF, 32'd0, "illegal imm");
        check("illegal flag", 64'(illegal), 64'd1);
        check("illegal funct7", 64'(funct7), 64'd0);
        step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            wb_en    = 1'($urandom_range(0, 1));
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            if_pc    = $urandom & 32'hFFFF_FFFC;
            ins        = $urandom;
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            ins[6:0]   = pick_opc(int'($urandom_range(0, 9)));
            if_instr   = ins;
            step();
        end

        // Asynchronous reset in the middle of a held beat
        flush = 1'b0; wb_en = 1'b0; ex_ready = 1'b1;
        beat_imm(32'h400, 32'hFFF0_0093, 32'hFFFF_FFFF, "pre-reset imm");
        ex_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async reset ex_valid", 64'(ex_valid), 64'd0);
        check("async reset pc", 64'(pc_out), 64'd0);
        check("async reset imm", 64'(imm_out), 64'd0);
        check("async reset rd", 64'(rd_out), 64'd0);
        #4 rst_n = 1'b1;
        step();
        ex_ready = 1'b1;
        beat_imm(32'h500, 32'h0052_8333, 32'd0, "post-reset imm");
        check("post-reset x5 cleared", 64'(rs1_out), 64'd0);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
